// File: rtl/mem_dump_reader.sv
// Debug-side data-memory dump engine: reads words 0..count-1 through a synchronous
// read port and streams each one MSB-first as bytes over a valid/ready handshake.
module mem_dump_reader #(
  parameter int NB_ADDR   = 32,
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int MEM_DEPTH = 256,
  parameter int NB_CNT    = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_CNT-1:0]  i_word_count,
  output logic               o_mem_read_en,
  output logic [NB_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam logic [NB_CNT-1:0] DEPTH_CNT = NB_CNT'(MEM_DEPTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_CNT-1:0]  r_count;
  logic [NB_CNT-1:0]  r_word_idx;
  logic [1:0]         r_byte_idx;
  logic [NB_DATA-1:0] r_shift;

  logic [NB_CNT-1:0]  w_clamped;
  logic               w_xfer;
  logic               w_last_byte;
  logic               w_last_word;

  // Requests longer than the memory are clipped so the word index cannot run off the end
  assign w_clamped   = (i_word_count > DEPTH_CNT) ? DEPTH_CNT : i_word_count;
  assign w_xfer      = (r_state == SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == (r_count - NB_CNT'(1)));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    o_mem_read_en = 1'b0;
    o_mem_addr    = '0;
    o_tx_valid    = 1'b0;
    o_tx_data     = '0;
    o_busy        = 1'b1;
    o_done        = 1'b0;

    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next_state = (w_clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        o_mem_read_en = 1'b1;
        o_mem_addr    = NB_ADDR'({r_word_idx, 2'b00});
        w_next_state  = WAIT;
      end
      WAIT: begin
        w_next_state = SEND;
      end
      SEND: begin
        o_tx_valid = 1'b1;
        case (r_byte_idx)
          2'd0:    o_tx_data = r_shift[4*NB_BYTE-1 -: NB_BYTE];
          2'd1:    o_tx_data = r_shift[3*NB_BYTE-1 -: NB_BYTE];
          2'd2:    o_tx_data = r_shift[2*NB_BYTE-1 -: NB_BYTE];
          default: o_tx_data = r_shift[NB_BYTE-1 -: NB_BYTE];
        endcase
        if (w_xfer && w_last_byte) begin
          w_next_state = w_last_word ? DONE : READ;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Memory data is captured at the end of WAIT, one cycle after the READ strobe
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count    <= w_clamped;
            r_word_idx <= '0;
          end
        end
        WAIT: begin
          r_shift    <= i_mem_data;
          r_byte_idx <= '0;
        end
        SEND: begin
          if (w_xfer) begin
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end else if (!w_last_word) begin
              r_word_idx <= r_word_idx + NB_CNT'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: table of dump requests against a byte/address
// scoreboard, plus hand-built sequences for back-pressure, ignored start and mid-dump reset.
module tb_mem_dump_reader;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [8:0]  i_word_count;
  logic        o_mem_read_en;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] tbMem [256];
  logic [31:0] memQ;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [7:0]  expBytes [$];
  logic [31:0] expAddrs [$];
  int          txCount;
  int          rdCount;
  logic [31:0] lastAddr;

  typedef struct {
    logic [8:0]  wordCount;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m2;
    int          expWords;
    int          expDone;
    int          expFirst;
  } vec_t;

  vec_t vecs [6];

  always #5 clock = ~clock;

  mem_dump_reader #(
    .NB_ADDR(32), .NB_DATA(32), .NB_BYTE(8), .MEM_DEPTH(256), .NB_CNT(9)
  ) dut (
    .i_clock      (clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .o_mem_read_en(o_mem_read_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Synchronous-read data memory: data appears the cycle after the read strobe
  always @(posedge clock) begin
    if (o_mem_read_en) memQ <= tbMem[o_mem_addr[9:2]];
  end
  assign i_mem_data = memQ;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every transferred byte and every read strobe is matched in order
  always @(negedge clock) begin
    if (i_reset) begin
      if (o_tx_valid && i_tx_ready) begin
        txCount++;
        if (expBytes.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", o_tx_data);
        end else begin
          checkOutput("stream byte", 32'(o_tx_data), 32'(expBytes.pop_front()));
        end
      end
      if (o_mem_read_en) begin
        rdCount++;
        lastAddr = o_mem_addr;
        if (expAddrs.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected read: got addr 0x%0h, expected none", o_mem_addr);
        end else begin
          checkOutput("read address", o_mem_addr, expAddrs.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fillMem();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      tbMem[i] = {b, ~b, 8'hA5, b ^ 8'h3C};
    end
  endtask

  // Drives a start in the current cycle (cycle 0) and returns in cycle 1
  task automatic applyStimulus(input logic [8:0] wc, input int expWords);
    for (int w = 0; w < expWords; w++) begin
      logic [31:0] word;
      word = tbMem[w];
      expAddrs.push_back(32'(w * 4));
      expBytes.push_back(word[31:24]);
      expBytes.push_back(word[23:16]);
      expBytes.push_back(word[15:8]);
      expBytes.push_back(word[7:0]);
    end
    txCount      = 0;
    rdCount      = 0;
    lastAddr     = 32'hFFFF_FFFF;
    i_word_count = wc;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic runToDone(input int startCyc, input int budget, output int doneCyc, output int firstValid);
    doneCyc    = -1;
    firstValid = -1;
    for (int c = startCyc; c < startCyc + budget; c++) begin
      if (o_tx_valid && firstValid < 0) firstValid = c;
      if (o_done) begin
        doneCyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic checkAfterDump(input int expWords);
    tick();
    checkOutput("busy after done", 32'(o_busy), 32'd0);
    checkOutput("bytes sent", 32'(txCount), 32'(4 * expWords));
    checkOutput("read strobes", 32'(rdCount), 32'(expWords));
    if (expWords > 0) checkOutput("last read address", lastAddr, 32'((expWords - 1) * 4));
    checkOutput("bytes left", 32'(expBytes.size()), 32'd0);
    expBytes.delete();
    expAddrs.delete();
  endtask

  initial begin
    int doneCyc;
    int firstValid;

    vecs[0] = '{9'd1,   32'hDEADBEEF, 32'h0,        32'h0,        1,   7,    3};
    vecs[1] = '{9'd3,   32'h00000001, 32'h11223344, 32'hFFFFFFFF, 3,   19,   3};
    vecs[2] = '{9'd0,   32'h12345678, 32'h0,        32'h0,        0,   1,    -1};
    vecs[3] = '{9'd300, 32'h01020304, 32'hA0B0C0D0, 32'h55AA55AA, 256, 1537, 3};
    vecs[4] = '{9'd256, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0, 256, 1537, 3};
    vecs[5] = '{9'd2,   32'h7F800001, 32'h80000000, 32'h0,        2,   13,   3};

    i_reset      = 1'b0;
    i_start      = 1'b0;
    i_word_count = '0;
    i_tx_ready   = 1'b1;
    fillMem();
    repeat (3) tick();

    checkOutput("reset read_en", 32'(o_mem_read_en), 32'd0);
    checkOutput("reset addr", o_mem_addr, 32'd0);
    checkOutput("reset tx_data", 32'(o_tx_data), 32'd0);
    checkOutput("reset tx_valid", 32'(o_tx_valid), 32'd0);
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);
    i_reset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      fillMem();
      tbMem[0] = vecs[v].m0;
      tbMem[1] = vecs[v].m1;
      tbMem[2] = vecs[v].m2;
      applyStimulus(vecs[v].wordCount, vecs[v].expWords);
      runToDone(1, 2000, doneCyc, firstValid);
      checkOutput($sformatf("vec%0d done cycle", v), 32'(doneCyc), 32'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d first valid", v), 32'(firstValid), 32'(vecs[v].expFirst));
      checkAfterDump(vecs[v].expWords);
    end

    // Back-pressure on byte 1 of 0xCAFEBABE
    fillMem();
    tbMem[0] = 32'hCAFEBABE;
    applyStimulus(9'd1, 1);
    repeat (3) tick();
    i_tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall tx_data", 32'(o_tx_data), 32'hFE);
      checkOutput("stall tx_valid", 32'(o_tx_valid), 32'd1);
      tick();
    end
    i_tx_ready = 1'b1;
    runToDone(9, 50, doneCyc, firstValid);
    checkOutput("stall done cycle", 32'(doneCyc), 32'd12);
    checkAfterDump(1);

    // Start pulse in the middle of a dump must be ignored
    fillMem();
    applyStimulus(9'd2, 2);
    repeat (4) tick();
    i_start      = 1'b1;
    i_word_count = 9'd5;
    checkOutput("busy during ignored start", 32'(o_busy), 32'd1);
    tick();
    i_start = 1'b0;
    checkOutput("busy after ignored start", 32'(o_busy), 32'd1);
    runToDone(6, 50, doneCyc, firstValid);
    checkOutput("ignored start done cycle", 32'(doneCyc), 32'd13);
    checkAfterDump(2);

    // Reset while word 1 is being sent, then a fresh dump from address 0
    fillMem();
    applyStimulus(9'd2, 2);
    repeat (9) tick();
    i_reset = 1'b0;
    #1;
    checkOutput("mid reset read_en", 32'(o_mem_read_en), 32'd0);
    checkOutput("mid reset addr", o_mem_addr, 32'd0);
    checkOutput("mid reset tx_data", 32'(o_tx_data), 32'd0);
    checkOutput("mid reset tx_valid", 32'(o_tx_valid), 32'd0);
    checkOutput("mid reset busy", 32'(o_busy), 32'd0);
    checkOutput("mid reset done", 32'(o_done), 32'd0);
    checkOutput("abandoned bytes", 32'(expBytes.size()), 32'd3);
    expBytes.delete();
    expAddrs.delete();
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    tbMem[0] = 32'h0BADF00D;
    applyStimulus(9'd1, 1);
    runToDone(1, 50, doneCyc, firstValid);
    checkOutput("post reset done cycle", 32'(doneCyc), 32'd7);
    checkOutput("post reset first valid", 32'(firstValid), 32'd3);
    checkAfterDump(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Debug-side reader for the data memory that the MEM stage writes during program execution.
- On a start pulse, reads a contiguous range of data-memory words from address 0 upward through a synchronous read port.
- Serialises each word MSB-first as a byte stream with a valid/ready handshake toward the debug UART transmitter.
- Sits beside the pipeline and is used only while the pipeline is halted. The debug unit multiplexes it onto the data memory address/read lines.

Parameters:
- NB_ADDR, 32, byte-address width driven to data memory.
- NB_DATA, 32, data-memory word width; fixed at 4 bytes.
- NB_BYTE, 8, width of the output stream symbol.
- MEM_DEPTH, 256, data-memory depth in words; upper bound on dump length.
- NB_CNT, 9, word-count width; equals clog2(MEM_DEPTH)+1.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request to begin a dump; honoured only in IDLE.
- i_word_count  in  NB_CNT  number of words to dump; sampled on an accepted i_start.
- o_mem_read_en  out  1  read strobe to data memory.
- o_mem_addr  out  NB_ADDR  word-aligned byte address to data memory.
- i_mem_data  in  NB_DATA  read data; valid one cycle after the o_mem_read_en cycle.
- o_tx_data  out  NB_BYTE  byte to transmitter.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  transmitter accepts the byte this cycle.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE, word index=0, byte index=0, shift register=0.
  - All outputs 0.
  - Takes effect mid-dump with no flush; a partially sent word is abandoned.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - On i_start=1, latch count = min(i_word_count, MEM_DEPTH) and set word index=0.
  - If the latched count is 0, go to DONE; otherwise go to READ.
  - i_start in any other state is ignored and not queued.
- READ (exactly 1 cycle):
  - o_mem_read_en=1, o_mem_addr = word_index*4 (upper bits zero).
  - Go to WAIT.
- WAIT (exactly 1 cycle):
  - o_mem_read_en=0.
  - Capture i_mem_data into the shift register at the clock edge ending this cycle.
  - Set byte index=0 and go to SEND.
- SEND:
  - o_tx_valid=1, o_tx_data = shift_register[31:24] for byte 0, [23:16] for byte 1, [15:8] for byte 2, [7:0] for byte 3.
  - o_tx_data and o_tx_valid hold stable while o_tx_valid=1 and i_tx_ready=0.
  - A transfer occurs on the edge where o_tx_valid=1 and i_tx_ready=1.
  - On transfer of bytes 0–2: byte index +1.
  - On transfer of byte 3: if word_index == count-1, go to DONE; otherwise word_index +1 and go to READ.
  - o_tx_valid drops to 0 in the cycle after the last byte of a word transfers.
- DONE (1 cycle):
  - o_done=1, then return to IDLE. o_busy goes low in IDLE.
- Latency:
  - First byte valid 3 cycles after the i_start edge (IDLE→READ→WAIT→SEND).
  - With i_tx_ready tied high, each word costs 6 cycles (READ, WAIT, 4×SEND).
  - A dump of N words therefore lasts 6N cycles, plus the IDLE cycle that accepts i_start and 1 DONE cycle.
- Never asserts o_mem_read_en outside READ. Never issues any memory write.
- Counter widths must cover MEM_DEPTH without wrap; word_index never exceeds count-1.

Test Plan:
- Single word: preload mem[0]=0xDEADBEEF, i_word_count=1, i_tx_ready=1.
  - Bytes DE, AD, BE, EF on consecutive cycles starting 3 cycles after start.
  - o_done 1 cycle after byte EF; o_mem_addr=0 during READ.
- Multi-word: preload mem[0..2]=0x00000001, 0x11223344, 0xFFFFFFFF, count=3.
  - 12-byte stream 00 00 00 01 11 22 33 44 FF FF FF FF.
  - Read addresses 0x0, 0x4, 0x8.
- Back-pressure: i_tx_ready low for 5 cycles while byte 1 of 0xCAFEBABE is presented.
  - o_tx_data stays 0xFE and o_tx_valid stays 1 throughout.
  - Stream resumes BA, BE; no byte lost or duplicated.
- Boundary counts:
  - i_word_count=0 → o_done pulse 1 cycle after start, no read strobe, no valid.
  - i_word_count=300 with MEM_DEPTH=256 → exactly 1024 bytes sent, last read address 0x3FC.
- i_start asserted mid-dump: no effect on the stream or the latched count; o_busy stays 1.
- Reset mid-dump: i_reset=0 during SEND of word 1.
  - All outputs 0 immediately.
  - A new start after release dumps again from address 0.
